regfile_wb_arbiter: RTL and testbench

Register-file write-back controller for the NPC core. It keeps a 32-entry busy scoreboard over the general-purpose registers and stalls issue on RAW and WAW hazards. It arbitrates round-robin between two write-back requesters, EXU and LSU, for the single register-file write port. Its registered outputs drive the register file's write enable, destination index and write data directly.

---
 rtl/regfile_wb_arbiter.sv | 129 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back controller: busy scoreboard with RAW/WAW issue stall,
// round-robin EXU/LSU arbitration, and a registered single write port.

module regfile_wb_busy_cell (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic set,
  input  logic clr,
  output logic busy
);
  logic busy_q, busy_d;

  // Priority: flush over set over clear.
  always_comb begin
    busy_d = busy_q;
    if (clr)   busy_d = 1'b0;
    if (set)   busy_d = 1'b1;
    if (flush) busy_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= 1'b0;
    else      busy_q <= busy_d;
  end

  assign busy = busy_q;
endmodule

module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int RW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [RW-1:0]   iss_rs1,
  input  logic [RW-1:0]   iss_rs2,
  input  logic [RW-1:0]   iss_rd,
  input  logic            iss_wen,
  input  logic            exu_valid,
  output logic            exu_ready,
  input  logic [RW-1:0]   exu_rd,
  input  logic [XLEN-1:0] exu_wd,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [RW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_wd,
  output logic            rf_wen,
  output logic [RW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wd,
  output logic [NREG-1:0] busy_vec,
  output logic            wb_err
);
  typedef enum logic {PTR_EXU = 1'b0, PTR_LSU = 1'b1} ptr_e;

  ptr_e            ptr_q, ptr_d;
  logic            rf_wen_q, rf_wen_d;
  logic [RW-1:0]   rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wd_q, rf_wd_d;
  logic            wb_err_q, wb_err_d;

  logic            exu_gnt, lsu_gnt, any_gnt;
  logic [RW-1:0]   gnt_rd;
  logic [XLEN-1:0] gnt_wd;
  logic            iss_set;

  // Issue check reads registered busy only; a write retiring this cycle is not bypassed.
  assign iss_ready = !flush && !busy_vec[iss_rs1] && !busy_vec[iss_rs2]
                     && !(iss_wen && busy_vec[iss_rd]);
  assign iss_set   = iss_valid && iss_ready && iss_wen;

  always_comb begin
    exu_gnt  = exu_valid && (!lsu_valid || ptr_q == PTR_EXU);
    lsu_gnt  = lsu_valid && (!exu_valid || ptr_q == PTR_LSU);
    any_gnt  = exu_gnt || lsu_gnt;
    gnt_rd   = lsu_gnt ? lsu_rd : exu_rd;
    gnt_wd   = lsu_gnt ? lsu_wd : exu_wd;

    ptr_d    = ptr_q;
    if (exu_gnt) ptr_d = PTR_LSU;
    if (lsu_gnt) ptr_d = PTR_EXU;

    rf_wen_d = any_gnt && (gnt_rd != '0);
    rf_rd_d  = any_gnt ? gnt_rd : rf_rd_q;
    rf_wd_d  = any_gnt ? gnt_wd : rf_wd_q;
    wb_err_d = rf_wen_d && !busy_vec[gnt_rd];
  end

  assign exu_ready = exu_gnt;
  assign lsu_ready = lsu_gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q    <= PTR_LSU;
      rf_wen_q <= 1'b0;
      rf_rd_q  <= '0;
      rf_wd_q  <= '0;
      wb_err_q <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      rf_wen_q <= rf_wen_d;
      rf_rd_q  <= rf_rd_d;
      rf_wd_q  <= rf_wd_d;
      wb_err_q <= wb_err_d;
    end
  end

  // x0 is hardwired idle; every other register gets its own scoreboard cell.
  assign busy_vec[0] = 1'b0;
  for (genvar i = 1; i < NREG; i++) begin : g_busy
    regfile_wb_busy_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .flush(flush),
      .set  (iss_set && (iss_rd == RW'(i))),
      .clr  (rf_wen_q && (rf_rd_q == RW'(i))),
      .busy (busy_vec[i])
    );
  end

  assign rf_wen = rf_wen_q;
  assign rf_rd  = rf_rd_q;
  assign rf_wd  = rf_wd_q;
  assign wb_err = wb_err_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand sequences, and a
// randomized run against a scoreboard-level reference model.

module tb_regfile_wb_arbiter;
  logic        clk, rst, flush;
  logic        iss_valid, iss_ready, iss_wen;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        exu_valid, exu_ready, lsu_valid, lsu_ready;
  logic [4:0]  exu_rd, lsu_rd, rf_rd;
  logic [31:0] exu_wd, lsu_wd, rf_wd, busy_vec;
  logic        rf_wen, wb_err;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rs1(iss_rs1),
    .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_wen(iss_wen),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_wd(exu_wd),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wd(rf_wd), .busy_vec(busy_vec), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit [31:0] flush, iv, rs1, rs2, rd, wen;
    bit [31:0] ev, erd, ewd;
    bit [31:0] lv, lrd, lwd;
    bit [31:0] x_ir, x_er, x_lr, x_wen, x_rd, x_wd, x_busy, x_err, chk_d;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    flush = 0; iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0; iss_wen = 0;
    exu_valid = 0; exu_rd = 0; exu_wd = 0; lsu_valid = 0; lsu_rd = 0; lsu_wd = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  // Reference model state
  logic [31:0] m_busy;
  bit          m_pref_lsu;
  bit          m_wen, m_err;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;

  initial begin
    rst = 0;
    idle();
    #12;
    chk("reset_rf_wen", rf_wen, 0);
    chk("reset_rf_rd", rf_rd, 0);
    chk("reset_rf_wd", rf_wd, 0);
    chk("reset_busy", busy_vec, 0);
    chk("reset_wb_err", wb_err, 0);
    @(negedge clk);
    rst = 1;

    //        flush iv rs1 rs2 rd wen  ev erd ewd           lv lrd lwd    ir er lr wen rd wd            busy   err chk
    vt[0]  = '{0,1,0,0,5,1, 0,0,0,           0,0,0,      1,0,0,0,0,0,            0,     0,1};
    vt[1]  = '{0,1,5,0,0,0, 1,5,32'hDEADBEEF,0,0,0,      0,1,0,0,0,0,            32'h20,0,1};
    vt[2]  = '{0,1,5,0,0,0, 0,0,0,           0,0,0,      0,0,0,1,5,32'hDEADBEEF, 32'h20,0,1};
    vt[3]  = '{0,1,5,0,0,0, 0,0,0,           0,0,0,      1,0,0,0,5,32'hDEADBEEF, 0,     0,1};
    vt[4]  = '{0,1,0,0,3,1, 0,0,0,           0,0,0,      1,0,0,0,5,32'hDEADBEEF, 0,     0,1};
    vt[5]  = '{0,1,0,0,4,1, 0,0,0,           0,0,0,      1,0,0,0,5,32'hDEADBEEF, 32'h08,0,1};
    vt[6]  = '{0,0,0,0,0,0, 1,3,32'h33,      1,4,32'h44, 1,0,1,0,5,32'hDEADBEEF, 32'h18,0,1};
    vt[7]  = '{0,0,0,0,0,0, 1,3,32'h33,      0,0,0,      1,1,0,1,4,32'h44,       32'h18,0,1};
    vt[8]  = '{0,0,0,0,0,0, 0,0,0,           0,0,0,      1,0,0,1,3,32'h33,       32'h08,0,1};
    vt[9]  = '{0,0,0,0,0,0, 0,0,0,           0,0,0,      1,0,0,0,3,32'h33,       0,     0,1};
    vt[10] = '{0,1,0,0,0,1, 0,0,0,           0,0,0,      1,0,0,0,3,32'h33,       0,     0,1};
    vt[11] = '{0,0,0,0,0,0, 1,0,32'h55,      0,0,0,      1,1,0,0,3,32'h33,       0,     0,1};
    vt[12] = '{0,0,0,0,0,0, 0,0,0,           0,0,0,      1,0,0,0,0,0,            0,     0,0};
    vt[13] = '{0,1,0,0,6,1, 0,0,0,           0,0,0,      1,0,0,0,0,0,            0,     0,0};
    vt[14] = '{1,1,0,0,7,1, 0,0,0,           1,6,32'h66, 0,0,1,0,0,0,            32'h40,0,0};
    vt[15] = '{0,0,0,0,0,0, 0,0,0,           0,0,0,      1,0,0,1,6,32'h66,       0,     0,1};
    vt[16] = '{0,0,0,0,0,0, 0,0,0,           1,9,32'h99, 1,0,1,0,6,32'h66,       0,     0,1};
    vt[17] = '{0,0,0,0,0,0, 0,0,0,           0,0,0,      1,0,0,1,9,32'h99,       0,     1,1};

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      flush = vt[i].flush[0]; iss_valid = vt[i].iv[0];
      iss_rs1 = vt[i].rs1[4:0]; iss_rs2 = vt[i].rs2[4:0]; iss_rd = vt[i].rd[4:0];
      iss_wen = vt[i].wen[0];
      exu_valid = vt[i].ev[0]; exu_rd = vt[i].erd[4:0]; exu_wd = vt[i].ewd;
      lsu_valid = vt[i].lv[0]; lsu_rd = vt[i].lrd[4:0]; lsu_wd = vt[i].lwd;
      #1;
      chk($sformatf("v%0d_iss_ready", i), iss_ready, vt[i].x_ir);
      chk($sformatf("v%0d_exu_ready", i), exu_ready, vt[i].x_er);
      chk($sformatf("v%0d_lsu_ready", i), lsu_ready, vt[i].x_lr);
      chk($sformatf("v%0d_rf_wen", i), rf_wen, vt[i].x_wen);
      chk($sformatf("v%0d_busy", i), busy_vec, vt[i].x_busy);
      chk($sformatf("v%0d_wb_err", i), wb_err, vt[i].x_err);
      if (vt[i].chk_d != 0) begin
        chk($sformatf("v%0d_rf_rd", i), rf_rd, vt[i].x_rd);
        chk($sformatf("v%0d_rf_wd", i), rf_wd, vt[i].x_wd);
      end
    end

    // Asynchronous reset while a write (with error) is pending.
    @(negedge clk);
    idle();
    lsu_valid = 1; lsu_rd = 10; lsu_wd = 32'hAA;
    iss_valid = 1; iss_rd = 11; iss_wen = 1;
    @(posedge clk);
    #2;
    chk("pre_rst_rf_wen", rf_wen, 1);
    chk("pre_rst_wb_err", wb_err, 1);
    chk("pre_rst_busy", busy_vec, 32'h800);
    rst = 0;
    #1;
    chk("async_rst_rf_wen", rf_wen, 0);
    chk("async_rst_busy", busy_vec, 0);
    chk("async_rst_wb_err", wb_err, 0);
    idle();
    @(negedge clk);
    rst = 1;

    // Both requesters held for 6 cycles: grants alternate starting with LSU.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 6) begin
        exu_valid = 1; exu_rd = 1; exu_wd = 32'h100 + k;
        lsu_valid = 1; lsu_rd = 2; lsu_wd = 32'h200 + k;
      end else begin
        idle();
      end
      #1;
      if (k < 6) begin
        chk($sformatf("alt%0d_lsu_ready", k), lsu_ready, (k % 2 == 0));
        chk($sformatf("alt%0d_exu_ready", k), exu_ready, (k % 2 == 1));
      end
      if (k > 0) begin
        chk($sformatf("alt%0d_rf_wen", k), rf_wen, 1);
        chk($sformatf("alt%0d_rf_rd", k), rf_rd, ((k - 1) % 2 == 0) ? 2 : 1);
        chk($sformatf("alt%0d_rf_wd", k), rf_wd,
            ((k - 1) % 2 == 0) ? 32'h200 + k - 1 : 32'h100 + k - 1);
      end
    end

    // Randomized run against the reference model.
    do_reset();
    m_busy = 0; m_pref_lsu = 1; m_wen = 0; m_err = 0; m_rd = 0; m_wd = 0;
    for (int c = 0; c < 400; c++) begin
      int g;
      bit exp_ir;
      logic [31:0] nb;
      @(negedge clk);
      flush     = ($urandom_range(0, 15) == 0);
      iss_valid = $urandom_range(0, 1);
      iss_rs1   = 5'($urandom_range(0, 7));
      iss_rs2   = 5'($urandom_range(0, 7));
      iss_rd    = 5'($urandom_range(0, 7));
      iss_wen   = $urandom_range(0, 1);
      exu_valid = $urandom_range(0, 1);
      exu_rd    = 5'($urandom_range(0, 7));
      exu_wd    = $urandom;
      lsu_valid = $urandom_range(0, 1);
      lsu_rd    = 5'($urandom_range(0, 7));
      lsu_wd    = $urandom;
      #1;
      exp_ir = !flush && !m_busy[iss_rs1] && !m_busy[iss_rs2] && !(iss_wen && m_busy[iss_rd]);
      if (exu_valid && lsu_valid) g = m_pref_lsu ? 2 : 1;
      else if (exu_valid)         g = 1;
      else if (lsu_valid)         g = 2;
      else                        g = 0;
      chk("rnd_iss_ready", iss_ready, exp_ir);
      chk("rnd_exu_ready", exu_ready, g == 1);
      chk("rnd_lsu_ready", lsu_ready, g == 2);
      chk("rnd_rf_wen", rf_wen, m_wen);
      chk("rnd_busy", busy_vec, m_busy);
      chk("rnd_wb_err", wb_err, m_err);
      if (m_wen) begin
        chk("rnd_rf_rd", rf_rd, m_rd);
        chk("rnd_rf_wd", rf_wd, m_wd);
      end
      nb = m_busy;
      if (m_wen) nb[m_rd] = 1'b0;
      if (iss_valid && exp_ir && iss_wen && iss_rd != 0) nb[iss_rd] = 1'b1;
      if (flush) nb = 0;
      if (g != 0) begin
        logic [4:0] grd;
        grd    = (g == 2) ? lsu_rd : exu_rd;
        m_wen  = (grd != 0);
        m_err  = (grd != 0) && !m_busy[grd];
        m_rd   = grd;
        m_wd   = (g == 2) ? lsu_wd : exu_wd;
        m_pref_lsu = (g == 1);
      end else begin
        m_wen = 0;
        m_err = 0;
      end
      m_busy = nb;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
